change_dispenser: RTL and testbench

//  Payout side of the vending datapath: accepts a change amount from the vending FSM and ejects coins one at a time.

---
 rtl/vending_pkg.sv | 68 ++++++
 rtl/coin_inventory.sv | 55 +++++
 rtl/change_dispenser.sv | 175 +++++++++++++++++
 tb/tb_change_dispenser.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vending_pkg
// Description : Shared encodings for the vending datapath: payout FSM states,
//               coin codes, the 5 Tk money unit and 7-segment digit patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package vending_pkg;

    // Payout FSM state encoding
    localparam int c_STATE_W = 3;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE     = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_SELECT   = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_REQ      = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT_REL = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_DONE     = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_FAULT    = 3'd5;

    // Coin type as presented on eject_coin
    localparam logic c_COIN_05 = 1'b0;
    localparam logic c_COIN_10 = 1'b1;

    // One amount unit is worth this many Taka
    localparam int c_UNIT_TK = 5;

    // 7-segment patterns, bit order gfedcba, segment lit when 1
    localparam logic [6:0] c_SEG_0 = 7'h3F;
    localparam logic [6:0] c_SEG_1 = 7'h06;
    localparam logic [6:0] c_SEG_2 = 7'h5B;
    localparam logic [6:0] c_SEG_3 = 7'h4F;
    localparam logic [6:0] c_SEG_4 = 7'h66;
    localparam logic [6:0] c_SEG_5 = 7'h6D;
    localparam logic [6:0] c_SEG_6 = 7'h7D;
    localparam logic [6:0] c_SEG_7 = 7'h07;
    localparam logic [6:0] c_SEG_8 = 7'h7F;
    localparam logic [6:0] c_SEG_9 = 7'h6F;
    localparam logic [6:0] c_SEG_BLANK = 7'h00;

    // Number of amount units one coin of the given type pays off
    function automatic logic [1:0] coin_units(input logic coin);
        return (coin == c_COIN_10) ? 2'd2 : 2'd1;
    endfunction

    function automatic int units_to_tk(input int units);
        return units * c_UNIT_TK;
    endfunction

    function automatic logic [6:0] seg_digit(input logic [3:0] digit);
        logic [6:0] seg;
        seg = c_SEG_BLANK;
        case (digit)
            4'd0: seg = c_SEG_0;
            4'd1: seg = c_SEG_1;
            4'd2: seg = c_SEG_2;
            4'd3: seg = c_SEG_3;
            4'd4: seg = c_SEG_4;
            4'd5: seg = c_SEG_5;
            4'd6: seg = c_SEG_6;
            4'd7: seg = c_SEG_7;
            4'd8: seg = c_SEG_8;
            4'd9: seg = c_SEG_9;
            default: seg = c_SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coin_inventory.sv
`default_nettype none
// ============================================================================
// Module      : coin_inventory
// Description : Two coin down-counters (5 Tk / 10 Tk) with refill load and
//               per-type decrement; exposes empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_inventory #(
    parameter int INV_W       = 6,
    parameter int INV_INIT_05 = 20,
    parameter int INV_INIT_10 = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec_05,
    input  logic             dec_10,
    output logic [INV_W-1:0] count_05,
    output logic [INV_W-1:0] count_10,
    output logic             zero_05,
    output logic             zero_10
);

    localparam logic [INV_W-1:0] c_INIT_05 = INV_W'(INV_INIT_05);
    localparam logic [INV_W-1:0] c_INIT_10 = INV_W'(INV_INIT_10);
    localparam logic [INV_W-1:0] c_ONE     = INV_W'(1);

    logic [INV_W-1:0] r_count_05;
    logic [INV_W-1:0] r_count_10;

    // Decrements are additionally guarded so a counter can never wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count_05 <= c_INIT_05;
            r_count_10 <= c_INIT_10;
        end else if (load) begin
            r_count_05 <= c_INIT_05;
            r_count_10 <= c_INIT_10;
        end else begin
            if (dec_05 && (r_count_05 != '0)) begin
                r_count_05 <= r_count_05 - c_ONE;
            end
            if (dec_10 && (r_count_10 != '0)) begin
                r_count_10 <= r_count_10 - c_ONE;
            end
        end
    end

    assign count_05 = r_count_05;
    assign count_10 = r_count_10;
    assign zero_05  = (r_count_05 == '0);
    assign zero_10  = (r_count_10 == '0);

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Pays out change one coin at a time over a four-phase req/ack
//               ejector handshake, 10 Tk coins first, tracking inventory.
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W       = 3,
    parameter int INV_W       = 6,
    parameter int INV_INIT_05 = 20,
    parameter int INV_INIT_10 = 20,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             refill,
    output logic             eject_req,
    output logic             eject_coin,
    input  logic             eject_ack,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [INV_W-1:0] inv_05,
    output logic [INV_W-1:0] inv_10
);

    localparam int c_TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
    localparam logic [AMT_W-1:0]   c_AMT_TWO  = AMT_W'(2);

    logic [c_STATE_W-1:0] r_state;
    logic [AMT_W-1:0]     r_remaining;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic                 r_eject_req;
    logic                 r_eject_coin;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_fault;

    logic                 w_can_start;
    logic                 w_load;
    logic                 w_ack_taken;
    logic                 w_dec_05;
    logic                 w_dec_10;
    logic                 w_zero_05;
    logic                 w_zero_10;
    logic [AMT_W-1:0]     w_coin_units;

    // start and refill are only honoured while no payout is running
    assign w_can_start  = (r_state == c_ST_IDLE) || (r_state == c_ST_FAULT);
    assign w_load       = w_can_start && refill && !start;
    assign w_ack_taken  = (r_state == c_ST_REQ) && eject_ack;
    assign w_dec_05     = w_ack_taken && (r_eject_coin == c_COIN_05);
    assign w_dec_10     = w_ack_taken && (r_eject_coin == c_COIN_10);
    assign w_coin_units = AMT_W'(coin_units(r_eject_coin));

    coin_inventory #(
        .INV_W       (INV_W),
        .INV_INIT_05 (INV_INIT_05),
        .INV_INIT_10 (INV_INIT_10)
    ) u_coin_inventory (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_load),
        .dec_05   (w_dec_05),
        .dec_10   (w_dec_10),
        .count_05 (inv_05),
        .count_10 (inv_10),
        .zero_05  (w_zero_05),
        .zero_10  (w_zero_10)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_remaining  <= '0;
            r_tmo_cnt    <= '0;
            r_eject_req  <= 1'b0;
            r_eject_coin <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_FAULT: begin
                    if (start) begin
                        r_fault     <= 1'b0;
                        r_remaining <= amount;
                        if (amount == '0) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= c_ST_SELECT;
                        end
                    end else if (refill) begin
                        r_fault <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end

                // Greedy choice: a 10 Tk coin only if it does not overpay
                c_ST_SELECT: begin
                    if (r_remaining == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else if ((r_remaining >= c_AMT_TWO) && !w_zero_10) begin
                        r_eject_coin <= c_COIN_10;
                        r_eject_req  <= 1'b1;
                        r_tmo_cnt    <= '0;
                        r_state      <= c_ST_REQ;
                    end else if (!w_zero_05) begin
                        r_eject_coin <= c_COIN_05;
                        r_eject_req  <= 1'b1;
                        r_tmo_cnt    <= '0;
                        r_state      <= c_ST_REQ;
                    end else begin
                        r_busy  <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= c_ST_FAULT;
                    end
                end

                c_ST_REQ: begin
                    if (eject_ack) begin
                        r_remaining <= r_remaining - w_coin_units;
                        r_eject_req <= 1'b0;
                        r_state     <= c_ST_WAIT_REL;
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_eject_req <= 1'b0;
                        r_busy      <= 1'b0;
                        r_fault     <= 1'b1;
                        r_state     <= c_ST_FAULT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
                    end
                end

                c_ST_WAIT_REL: begin
                    if (!eject_ack) begin
                        r_state <= c_ST_SELECT;
                    end
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_eject_req <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign eject_req  = r_eject_req;
    assign eject_coin = r_eject_coin;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fault      = r_fault;
    assign remaining  = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_dispenser
// Description : Self-checking bench for change_dispenser: payout model,
//               ejector responder, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

    localparam int AMT_W  = 3;
    localparam int INV_W  = 6;
    localparam int INIT5  = 20;
    localparam int INIT10 = 20;
    localparam int TMO    = 15;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic             start     = 1'b0;
    logic [AMT_W-1:0] amount    = '0;
    logic             refill    = 1'b0;
    logic             eject_ack = 1'b0;
    logic             eject_req;
    logic             eject_coin;
    logic             busy;
    logic             done;
    logic             fault;
    logic [AMT_W-1:0] remaining;
    logic [INV_W-1:0] inv_05;
    logic [INV_W-1:0] inv_10;

    change_dispenser #(
        .AMT_W       (AMT_W),
        .INV_W       (INV_W),
        .INV_INIT_05 (INIT5),
        .INV_INIT_10 (INIT10),
        .ACK_TIMEOUT (TMO)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .amount     (amount),
        .refill     (refill),
        .eject_req  (eject_req),
        .eject_coin (eject_coin),
        .eject_ack  (eject_ack),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .remaining  (remaining),
        .inv_05     (inv_05),
        .inv_10     (inv_10)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Payout model: what a customer-facing payout must look like cycle by cycle
    typedef enum int {P_IDLE, P_PICK, P_ASK, P_RELEASE, P_FINISH, P_STUCK} phase_t;
    phase_t m_phase;
    int     m_rem, m_i5, m_i10, m_wait;
    bit     m_req, m_coin, m_busy, m_done, m_fault;

    task automatic model_reset();
        m_phase = P_IDLE;
        m_rem = 0; m_i5 = INIT5; m_i10 = INIT10; m_wait = 0;
        m_req = 0; m_coin = 0; m_busy = 0; m_done = 0; m_fault = 0;
    endtask

    task automatic model_step(input bit s, input int a, input bit r, input bit k);
        m_done = 0;
        case (m_phase)
            P_IDLE, P_STUCK: begin
                if (s) begin
                    m_fault = 0;
                    m_rem = a;
                    if (a == 0) begin m_done = 1; m_phase = P_FINISH; end
                    else begin m_busy = 1; m_phase = P_PICK; end
                end else if (r) begin
                    m_i5 = INIT5; m_i10 = INIT10; m_fault = 0; m_phase = P_IDLE;
                end
            end
            P_PICK: begin
                if (m_rem == 0) begin
                    m_done = 1; m_busy = 0; m_phase = P_FINISH;
                end else if (m_rem >= 2 && m_i10 > 0) begin
                    m_coin = 1; m_req = 1; m_wait = 0; m_phase = P_ASK;
                end else if (m_i5 > 0) begin
                    m_coin = 0; m_req = 1; m_wait = 0; m_phase = P_ASK;
                end else begin
                    m_busy = 0; m_fault = 1; m_phase = P_STUCK;
                end
            end
            P_ASK: begin
                if (k) begin
                    if (m_coin) begin m_rem -= 2; m_i10--; end
                    else begin m_rem -= 1; m_i5--; end
                    m_req = 0; m_phase = P_RELEASE;
                end else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        m_req = 0; m_busy = 0; m_fault = 1; m_phase = P_STUCK;
                    end
                end
            end
            P_RELEASE: if (!k) m_phase = P_PICK;
            P_FINISH:  m_phase = P_IDLE;
            default:   m_phase = P_IDLE;
        endcase
    endtask

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("eject_req", eject_req, m_req);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("fault", fault, m_fault);
            check("remaining", remaining, m_rem);
            check("inv_05", inv_05, m_i5);
            check("inv_10", inv_10, m_i10);
            if (m_req) check("eject_coin", eject_coin, m_coin);
        end
    end

    // Ejector responder and bookkeeping
    int ej_delay = 1, ej_hold = 1, ej_wait = 0, ej_held = 0;
    bit ej_mute = 0, spur_en = 0, prev_req = 0;
    int cycle = 0, req_rise_cycle = 0, end_cycle = 0, done_seen = 0;
    bit coins_q[$];

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step(start, int'(amount), refill, eject_ack);
        #1;
        cycle++;
        start = 0;
        refill = 0;
        if (eject_req && !prev_req) begin
            coins_q.push_back(eject_coin);
            req_rise_cycle = cycle;
        end
        prev_req = eject_req;
        if (done) done_seen++;
        if (eject_ack) begin
            ej_held++;
            if (ej_held >= ej_hold) begin eject_ack = 0; ej_wait = 0; end
        end else if (eject_req && !ej_mute) begin
            if (ej_wait >= ej_delay) begin eject_ack = 1; ej_held = 0; end
            else ej_wait++;
        end else begin
            ej_wait = 0;
        end
        if (spur_en && (eject_req || eject_ack) && ($urandom_range(0, 3) == 0)) begin
            start = 1;
            amount = AMT_W'($urandom_range(0, 7));
        end
        if (spur_en && busy && ($urandom_range(0, 7) == 0)) refill = 1;
    endtask

    task automatic run_payout(input int amt, input int bound);
        bit seen;
        seen = 0;
        start = 1;
        amount = AMT_W'(amt);
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done || fault) begin seen = 1; end_cycle = cycle; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL payout_end: no done or fault within %0d cycles, amount %0d", bound, amt);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_coin, second_coin, n10;
        bit found;
        model_reset();
        repeat (3) tick();
        reset_n = 1;
        cmp_en = 1;

        check("rst_eject_req", eject_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_remaining", remaining, 0);
        check("rst_inv_05", inv_05, 20);
        check("rst_inv_10", inv_10, 20);

        // amount 3: one 10 Tk then one 5 Tk
        ej_delay = 2; ej_hold = 1;
        coins_q.delete(); done_seen = 0;
        run_payout(3, 60);
        first_coin  = (coins_q.size() > 0) ? int'(coins_q[0]) : -1;
        second_coin = (coins_q.size() > 1) ? int'(coins_q[1]) : -1;
        check("t1_coin_count", coins_q.size(), 2);
        check("t1_first_coin", first_coin, 1);
        check("t1_second_coin", second_coin, 0);
        check("t1_inv_10", inv_10, 19);
        check("t1_inv_05", inv_05, 19);
        check("t1_remaining", remaining, 0);
        check("t1_done_pulses", done_seen, 1);

        // amount 0: done one cycle later, nothing ejected
        coins_q.delete();
        start = 1; amount = '0;
        tick();
        check("t2_done", done, 1);
        check("t2_busy", busy, 0);
        tick();
        check("t2_done_drop", done, 0);
        check("t2_no_req", coins_q.size(), 0);
        check("t2_inv_05", inv_05, 19);
        check("t2_inv_10", inv_10, 19);

        // no 10 Tk coins left: amount 4 paid in four 5 Tk coins
        refill = 1; tick();
        check("t3_refill_05", inv_05, 20);
        check("t3_refill_10", inv_10, 20);
        ej_delay = 0; ej_hold = 1;
        repeat (20) run_payout(2, 40);
        check("t3_tens_drained", inv_10, 0);
        coins_q.delete();
        run_payout(4, 80);
        n10 = 0;
        foreach (coins_q[i]) if (coins_q[i]) n10++;
        check("t3_coin_count", coins_q.size(), 4);
        check("t3_tens_used", n10, 0);
        check("t3_inv_05", inv_05, 16);
        check("t3_remaining", remaining, 0);

        // no 5 Tk coins, one 10 Tk coin: amount 3 faults with 1 unit unpaid
        refill = 1; tick();
        repeat (20) run_payout(1, 40);
        repeat (19) run_payout(2, 40);
        check("t4_inv_05", inv_05, 0);
        check("t4_inv_10", inv_10, 1);
        coins_q.delete();
        run_payout(3, 60);
        first_coin = (coins_q.size() > 0) ? int'(coins_q[0]) : -1;
        check("t4_fault", fault, 1);
        check("t4_remaining", remaining, 1);
        check("t4_coin_count", coins_q.size(), 1);
        check("t4_first_coin", first_coin, 1);
        check("t4_busy", busy, 0);
        refill = 1; tick();
        check("t4_fault_clr", fault, 0);
        check("t4_reload_05", inv_05, 20);
        check("t4_reload_10", inv_10, 20);

        // ejector never acknowledges
        ej_mute = 1;
        run_payout(5, 40);
        check("t5_fault", fault, 1);
        check("t5_req_low", eject_req, 0);
        check("t5_remaining", remaining, 5);
        check("t5_inv_05", inv_05, 20);
        check("t5_inv_10", inv_10, 20);
        check("t5_timeout_cycles", end_cycle - req_rise_cycle, 15);
        ej_mute = 0;

        // long ack plus stray start pulses while busy
        ej_delay = 1; ej_hold = 5; spur_en = 1;
        coins_q.delete(); done_seen = 0;
        run_payout(6, 120);
        spur_en = 0;
        tick();
        check("t6_done_pulses", done_seen, 1);
        check("t6_coin_count", coins_q.size(), 3);
        check("t6_inv_10", inv_10, 17);

        // reset asserted mid-request
        start = 1; amount = 3'd7;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (eject_req) begin found = 1; break; end
        end
        check("t6_req_seen", found, 1);
        #2;
        reset_n = 0;
        model_reset();
        eject_ack = 0; ej_wait = 0; ej_held = 0; prev_req = 0;
        #1;
        check("t6_rst_req", eject_req, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_remaining", remaining, 0);
        check("t6_rst_inv_05", inv_05, 20);
        check("t6_rst_inv_10", inv_10, 20);
        repeat (2) tick();
        reset_n = 1;
        tick();

        // randomized traffic
        spur_en = 1;
        for (int n = 0; n < 80; n++) begin
            ej_delay = $urandom_range(0, 3);
            ej_hold  = $urandom_range(1, 3);
            ej_mute  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 4) == 0) begin refill = 1; tick(); end
            run_payout($urandom_range(0, 7), 150);
            ej_mute = 0;
        end
        spur_en = 0;
        repeat (3) tick();

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
